// File: rtl/ps2_paddle_rx.sv
// PS/2 keyboard receiver that decodes W/S and E0-extended up/down arrows into held paddle keys.
// Define PS2_PADDLE_RX_PARITY_CHECK_EN to discard frames with bad odd parity; otherwise parity is ignored.
module ps2_paddle_rx #(
  parameter int         TIMEOUT_CYCLES = 5000,
  parameter logic [7:0] KEY_LU         = 8'h1D,
  parameter logic [7:0] KEY_LD         = 8'h1B,
  parameter logic [7:0] KEY_RU         = 8'h75,
  parameter logic [7:0] KEY_RD         = 8'h72
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [1:0] keys_left,
  output logic [1:0] keys_right
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            r_state, w_state_n;
  logic              r_clk_s1, r_clk_s2, r_clk_d;
  logic              r_dat_s1, r_dat_s2;
  logic [2:0]        r_bit_cnt, w_bit_cnt_n;
  logic [7:0]        r_shift, w_shift_n;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_vld_p1, r_err_p1;
  logic [7:0]        r_byte_p1;
  logic              r_ext, r_brk;
  logic              w_fall, w_timeout, w_par_ok, w_acc, w_err;

`ifdef PS2_PADDLE_RX_PARITY_CHECK_EN
  logic r_par, w_par_n;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  assign w_par_ok = odd_parity_ok(r_shift, r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_fall    = r_clk_d & ~r_clk_s2;
  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Stage p0: synchronizers plus one extra flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_bit_cnt_n = r_bit_cnt;
    w_shift_n   = r_shift;
`ifdef PS2_PADDLE_RX_PARITY_CHECK_EN
    w_par_n     = r_par;
`endif
    w_acc       = 1'b0;
    w_err       = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            w_state_n   = S_DATA;
            w_bit_cnt_n = 3'd0;
          end
        end
        S_DATA: begin
          w_shift_n   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_n = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_n = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PADDLE_RX_PARITY_CHECK_EN
          w_par_n   = r_dat_s2;
`endif
          w_state_n = S_STOP;
        end
        S_STOP: begin
          w_state_n = S_IDLE;
          if (r_dat_s2 && w_par_ok) w_acc = 1'b1;
          else                      w_err = 1'b1;
        end
        default: w_state_n = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_n = S_IDLE;
      w_err     = 1'b1;
    end
  end

  // Stage p1: frame FSM, timeout counter and accepted-byte strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_to_cnt  <= '0;
      r_vld_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_vld_p1  <= w_acc;
      r_err_p1  <= w_err;
      if (r_state == S_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                          r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_shift   <= w_shift_n;
    r_byte_p1 <= r_shift;
`ifdef PS2_PADDLE_RX_PARITY_CHECK_EN
    r_par     <= w_par_n;
`endif
  end

  // Stage p2: code output and make/break key decoding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      keys_left  <= 2'b00;
      keys_right <= 2'b00;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      code_valid <= r_vld_p1;
      frame_err  <= r_err_p1;
      if (r_vld_p1) begin
        code <= r_byte_p1;
        if (r_byte_p1 == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_byte_p1 == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          if (!r_ext && r_byte_p1 == KEY_LU) keys_left[1]  <= ~r_brk;
          if (!r_ext && r_byte_p1 == KEY_LD) keys_left[0]  <= ~r_brk;
          if (r_ext  && r_byte_p1 == KEY_RU) keys_right[1] <= ~r_brk;
          if (r_ext  && r_byte_p1 == KEY_RD) keys_right[0] <= ~r_brk;
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_paddle_rx.sv
// Randomized bench for ps2_paddle_rx against a scan-code level model of the held keys.
module tb_ps2_paddle_rx;

  localparam int HALF = 40;
`ifdef PS2_PADDLE_RX_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] code;
  logic       code_valid, frame_err;
  logic [1:0] keys_left, keys_right;

  ps2_paddle_rx dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .code(code), .code_valid(code_valid), .frame_err(frame_err),
    .keys_left(keys_left), .keys_right(keys_right)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int n_vld = 0, n_err = 0, vld_cyc = 0, err_cyc = 0;
  logic [1:0] vld_kl, vld_kr;
  int last_fall_cyc = 0;

  logic [1:0] m_kl = 2'b00, m_kr = 2'b00;
  logic       m_ext = 1'b0, m_brk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin
      n_vld   <= n_vld + 1;
      vld_cyc <= cyc;
      vld_kl  <= keys_left;
      vld_kr  <= keys_right;
    end
    if (frame_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scan-code semantics: E0 marks extended, F0 marks release, anything else resolves them.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && b == 8'h1D) m_kl[1] = ~m_brk;
      if (!m_ext && b == 8'h1B) m_kl[0] = ~m_brk;
      if (m_ext && b == 8'h75)  m_kr[1] = ~m_brk;
      if (m_ext && b == 8'h72)  m_kr[0] = ~m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1;
    ps2_dat = b;
    repeat (HALF) @(posedge clk);
    #1;
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(posedge clk);
    #1;
    ps2_clk = 1'b1;
  endtask

  task automatic send_check(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int  v0, e0;
    bit  exp_err;
    logic par;
    v0 = n_vld;
    e0 = n_err;
    exp_err = bad_stop || (PEN && bad_par);
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    repeat (20) @(posedge clk);
    @(negedge clk);
    if (!exp_err) model_byte(b);
    check("vld_count", n_vld - v0, exp_err ? 0 : 1);
    check("err_count", n_err - e0, exp_err ? 1 : 0);
    check("keys_left", keys_left, m_kl);
    check("keys_right", keys_right, m_kr);
    if (!exp_err) begin
      check("code", code, b);
      check("valid_latency", vld_cyc - last_fall_cyc, 4);
      check("keys_left_at_valid", vld_kl, m_kl);
      check("keys_right_at_valid", vld_kr, m_kr);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, t0;
    logic [7:0] tbl [8];
    logic [7:0] b;
    tbl[0] = 8'h1D; tbl[1] = 8'h1B; tbl[2] = 8'h75; tbl[3] = 8'h72;
    tbl[4] = 8'hE0; tbl[5] = 8'hF0; tbl[6] = 8'hE0; tbl[7] = 8'h00;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_code", code, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_keys_left", keys_left, 0);
    check("rst_keys_right", keys_right, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    send_check(8'h1D, 0, 0);
    send_check(8'hF0, 0, 0);
    send_check(8'h1D, 0, 0);
    send_check(8'hE0, 0, 0);
    send_check(8'h75, 0, 0);
    send_check(8'hE0, 0, 0);
    send_check(8'hF0, 0, 0);
    send_check(8'h75, 0, 0);
    send_check(8'hE0, 0, 0);
    send_check(8'h75, 0, 0);
    send_check(8'h75, 0, 0);
    send_check(8'h75, 0, 0);
    send_check(8'h1B, 1, 0);
    send_check(8'h1B, 0, 1);

    // Clock stalls after four data bits
    v0 = n_vld;
    e0 = n_err;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    t0 = last_fall_cyc;
    repeat (6000) @(posedge clk);
    @(negedge clk);
    check("timeout_err_count", n_err - e0, 1);
    check("timeout_vld_count", n_vld - v0, 0);
    check("timeout_latency_ok", int'((err_cyc - t0) >= 5000 && (err_cyc - t0) <= 5010), 1);
    check("timeout_keys_left", keys_left, m_kl);
    send_check(8'h1D, 0, 0);

    send_check(8'hF0, 0, 0);
    send_check(8'h1B, 0, 0);
    check("pre_reset_keys_left", keys_left, 2'b10);

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_code", code, 0);
    check("mid_rst_keys_left", keys_left, 0);
    check("mid_rst_keys_right", keys_right, 0);
    check("mid_rst_valid", code_valid, 0);
    m_kl = 2'b00; m_kr = 2'b00; m_ext = 1'b0; m_brk = 1'b0;
    repeat (10) @(posedge clk);
    send_check(8'h1B, 0, 0);

    for (int n = 0; n < 24; n++) begin
      b = tbl[$urandom_range(0, 7)];
      if (b == 8'h00) b = 8'($urandom);
      send_check(b, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
